// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing generator; VGA_FRAME_CNT_EN adds an 8-bit frame counter
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CNT_W    = 10,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_ena_i,
  output logic             hs_o,
  output logic             vs_o,
  output logic             d_ena_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             sol_o,
  output logic             sof_o
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt_o
`endif
);
  localparam int HMAX = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VMAX = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HMAX - 1);
  localparam logic [CNT_W-1:0] H_FP_S = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SY_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_S = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VMAX - 1);
  localparam logic [CNT_W-1:0] V_FP_S = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SY_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_S = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  if (HMAX > (1 << CNT_W) || VMAX > (1 << CNT_W))
    $error("vga_timing_gen: CNT_W too narrow for the line or frame total");

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;

  phase_t           h_st, v_st, h_nx, v_nx;
  logic [CNT_W-1:0] nx, ny;
  logic             x_wrap, y_wrap;

  // next position and phases; all outputs are decoded from these so they stay aligned with x_o/y_o
  always_comb begin
    x_wrap = x_o == H_LAST;
    y_wrap = y_o == V_LAST;
    nx     = x_wrap ? '0 : x_o + CNT_W'(1);
    ny     = x_wrap ? (y_wrap ? '0 : y_o + CNT_W'(1)) : y_o;
    h_nx   = (h_st == ACTIVE && nx == H_FP_S) ? FP :
             (h_st == FP     && nx == H_SY_S) ? SYNC :
             (h_st == SYNC   && nx == H_BP_S) ? BP :
             (h_st == BP     && nx == '0)     ? ACTIVE : h_st;
    v_nx   = !x_wrap ? v_st :
             (v_st == ACTIVE && ny == V_FP_S) ? FP :
             (v_st == FP     && ny == V_SY_S) ? SYNC :
             (v_st == SYNC   && ny == V_BP_S) ? BP :
             (v_st == BP     && ny == '0)     ? ACTIVE : v_st;
  end

  // counters, phase registers and registered outputs; everything holds without a pixel tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_o     <= '0;
      y_o     <= '0;
      h_st    <= ACTIVE;
      v_st    <= ACTIVE;
      hs_o    <= ~HS_POL;
      vs_o    <= ~VS_POL;
      d_ena_o <= 1'b1;
      sol_o   <= 1'b0;
      sof_o   <= 1'b0;
    end else begin
      sol_o <= pix_ena_i && x_wrap;
      sof_o <= pix_ena_i && x_wrap && y_wrap;
      if (pix_ena_i) begin
        x_o     <= nx;
        y_o     <= ny;
        h_st    <= h_nx;
        v_st    <= v_nx;
        hs_o    <= (h_nx == SYNC) ? HS_POL : ~HS_POL;
        vs_o    <= (v_nx == SYNC) ? VS_POL : ~VS_POL;
        d_ena_o <= (h_nx == ACTIVE) && (v_nx == ACTIVE);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // frame counter advances together with the start-of-frame strobe
  always_ff @(posedge clk_i) begin
    if (rst_i)
      frame_cnt_o <= '0;
    else if (pix_ena_i && x_wrap && y_wrap)
      frame_cnt_o <= frame_cnt_o + 8'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the default 640x480 mode and a tiny positive-polarity mode
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst, pix;
  logic d_hs, d_vs, d_de, d_sol, d_sof;
  logic [9:0] d_x, d_y;
  logic s_hs, s_vs, s_de, s_sol, s_sof;
  logic [3:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_fc, s_fc;
`endif
  int checks = 0, failures = 0;
  int dx, dy, sx, sy, dfc, sfc, cyc = 0, last_sof, last_sol, mul = 1;
  bit dw, dsf, sw, ssf;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk_i(clk), .rst_i(rst), .pix_ena_i(pix), .hs_o(d_hs), .vs_o(d_vs), .d_ena_o(d_de),
    .x_o(d_x), .y_o(d_y), .sol_o(d_sol), .sof_o(d_sof)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt_o(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CNT_W(4), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .pix_ena_i(pix), .hs_o(s_hs), .vs_o(s_vs), .d_ena_o(s_de),
    .x_o(s_x), .y_o(s_y), .sol_o(s_sol), .sof_o(s_sof)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt_o(s_fc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p);
    rst = r;
    pix = p;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      dx = 0; dy = 0; sx = 0; sy = 0; dfc = 0; sfc = 0;
      dw = 0; dsf = 0; sw = 0; ssf = 0;
      last_sof = -1; last_sol = -1;
    end else if (p) begin
      dw = dx == 799; dsf = dw && dy == 524;
      dx = dw ? 0 : dx + 1;
      if (dw) dy = (dy == 524) ? 0 : dy + 1;
      sw = sx == 9; ssf = sw && sy == 7;
      sx = sw ? 0 : sx + 1;
      if (sw) sy = (sy == 7) ? 0 : sy + 1;
      if (dsf) dfc = (dfc + 1) % 256;
      if (ssf) sfc = (sfc + 1) % 256;
    end else begin
      dw = 0; dsf = 0; sw = 0; ssf = 0;
    end
    chk("d_x", d_x, dx);
    chk("d_y", d_y, dy);
    chk("d_hs", d_hs, !(dx >= 656 && dx <= 751));
    chk("d_vs", d_vs, !(dy >= 490 && dy <= 491));
    chk("d_de", d_de, dx < 640 && dy < 480);
    chk("d_sol", d_sol, dw);
    chk("d_sof", d_sof, dsf);
    chk("s_x", s_x, sx);
    chk("s_y", s_y, sy);
    chk("s_hs", s_hs, sx >= 7 && sx <= 8);
    chk("s_vs", s_vs, sy >= 5 && sy <= 6);
    chk("s_de", s_de, sx < 6 && sy < 4);
    chk("s_sol", s_sol, sw);
    chk("s_sof", s_sof, ssf);
`ifdef VGA_FRAME_CNT_EN
    chk("d_fc", d_fc, dfc);
    chk("s_fc", s_fc, sfc);
`endif
    if (s_sof === 1'b1) begin
      if (last_sof >= 0) chk("s_frame_period", cyc - last_sof, 80 * mul);
      last_sof = cyc;
    end
    if (d_sol === 1'b1) begin
      if (last_sol >= 0) chk("d_line_period", cyc - last_sol, 800 * mul);
      last_sol = cyc;
    end
  endtask

  initial begin
    tick(1, 0);
    chk("rst_d_x", d_x, 0);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_d_de", d_de, 1);
    chk("rst_d_sof", d_sof, 0);
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 0);
    repeat (1700) tick(0, 1);
    chk("run_d_x", d_x, 100);
    chk("run_d_y", d_y, 2);
    tick(1, 1);
    repeat (1500) tick(0, 1);
    chk("pre_d_x", d_x, 700);
    chk("pre_d_y", d_y, 1);
    chk("pre_d_hs", d_hs, 0);
    chk("pre_s_vs", s_vs, 1);
    tick(1, 1);
    chk("post_d_x", d_x, 0);
    chk("post_d_y", d_y, 0);
    chk("post_d_de", d_de, 1);
    chk("post_d_hs", d_hs, 1);
    chk("post_d_vs", d_vs, 1);
    chk("post_d_sof", d_sof, 0);
    chk("post_s_vs", s_vs, 0);
    chk("post_s_sof", s_sof, 0);
    tick(0, 1);
    chk("resume_d_x", d_x, 1);
    chk("resume_s_x", s_x, 1);
    tick(1, 0);
    mul = 2;
    for (int i = 0; i < 520; i++) tick(0, i % 2 == 0);
    chk("tog_s_y", s_y, 2);
    chk("tog_s_x", s_x, 0);
`ifdef VGA_FRAME_CNT_EN
    tick(1, 0);
    mul = 1;
    repeat (256 * 80 + 1) tick(0, 1);
    chk("fc_after_256", s_fc, 0);
    repeat (80) tick(0, 1);
    chk("fc_after_257", s_fc, 1);
    chk("fc_default", d_fc, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
